// File: rtl/pipe_word_pkg.sv
// Shared widths, header/message layouts and FSM states for the portal pipe <-> host word bridge.
package pipe_word_pkg;

    localparam int unsigned HDR_W         = 16;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned PAYLOAD_WORDS = 4;
    localparam int unsigned PAYLOAD_W     = PAYLOAD_WORDS * WORD_W;
    localparam int unsigned MSG_W         = HDR_W + PAYLOAD_W;
    localparam int unsigned LEN_W         = 8;
    localparam int unsigned MID_W         = 8;
    localparam int unsigned TX_IDX_W      = 3;

    // Header: method id in [15:8], payload length in words in [7:0].
    typedef struct packed {
        logic [MID_W-1:0] mid;
        logic [LEN_W-1:0] len;
    } hdr_t;

    typedef struct packed {
        hdr_t                 hdr;
        logic [PAYLOAD_W-1:0] payload;
    } msg_t;

    typedef enum logic {
        T_IDLE,
        T_SEND
    } tx_state_t;

    typedef enum logic [1:0] {
        R_HDR,
        R_BODY,
        R_DELIVER
    } rx_state_t;

    function automatic logic len_over(input logic [LEN_W-1:0] len);
        return len > LEN_W'(PAYLOAD_WORDS);
    endfunction

    // Index of the last payload word actually sent (length clamped to the buffer).
    function automatic logic [TX_IDX_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return len_over(len) ? TX_IDX_W'(PAYLOAD_WORDS) : len[TX_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/l_pipe_word_bridge_ser.sv
// Transmit serialiser: buffers one message and emits the header word then min(L,4) payload words.
module l_pipe_word_ser
    import pipe_word_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              msg_ena,
    input  msg_t              msg,
    output logic              msg_rdy,
    output logic              word_ena,
    output logic [WORD_W-1:0] word,
    input  logic              word_rdy,
    output logic              err
);

    tx_state_t             state;
    tx_state_t             state_next;
    msg_t                  buf_q;
    logic [TX_IDX_W-1:0]   idx;
    logic [TX_IDX_W-1:0]   last_idx;
    logic                  err_q;
    logic                  msg_xfer;

    assign msg_xfer = msg_ena & (state == T_IDLE);
    assign err      = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= T_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            T_IDLE:  if (msg_xfer) state_next = T_SEND;
            T_SEND:  if (word_ena && idx == last_idx) state_next = T_IDLE;
            default: state_next = T_IDLE;
        endcase
    end

    // Word 0 is the zero-extended header; word i is payload word i-1.
    always_comb begin
        msg_rdy  = (state == T_IDLE);
        word_ena = (state == T_SEND) & word_rdy;
        word     = '0;
        if (state == T_SEND) begin
            case (idx)
                3'd0:    word = WORD_W'(buf_q.hdr);
                3'd1:    word = buf_q.payload[0*WORD_W +: WORD_W];
                3'd2:    word = buf_q.payload[1*WORD_W +: WORD_W];
                3'd3:    word = buf_q.payload[2*WORD_W +: WORD_W];
                3'd4:    word = buf_q.payload[3*WORD_W +: WORD_W];
                default: word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            idx      <= '0;
            last_idx <= '0;
            err_q    <= 1'b0;
        end else if (msg_xfer) begin
            buf_q    <= msg;
            idx      <= '0;
            last_idx <= clamp_len(msg.hdr.len);
            if (len_over(msg.hdr.len)) err_q <= 1'b1;
        end else if (word_ena) begin
            idx <= idx + TX_IDX_W'(1);
        end
    end

endmodule

// File: rtl/l_pipe_word_bridge.sv
// Host-side pipe bridge: TX serialises indication messages to words, RX assembles words into requests.
module l_pipe_word_bridge
    import pipe_word_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              indication_enq__ENA,
    input  logic [MSG_W-1:0]  indication_enq_v,
    output logic              indication_enq__RDY,
    output logic              txword_enq__ENA,
    output logic [WORD_W-1:0] txword_enq_v,
    input  logic              txword_enq__RDY,
    input  logic              rxword_enq__ENA,
    input  logic [WORD_W-1:0] rxword_enq_v,
    output logic              rxword_enq__RDY,
    output logic              request_enq__ENA,
    output logic [MSG_W-1:0]  request_enq_v,
    input  logic              request_enq__RDY,
    output logic              err_tx,
    output logic              err_rx
);

    l_pipe_word_ser u_ser (
        .clk      (CLK),
        .rst_n    (nRST),
        .msg_ena  (indication_enq__ENA),
        .msg      (msg_t'(indication_enq_v)),
        .msg_rdy  (indication_enq__RDY),
        .word_ena (txword_enq__ENA),
        .word     (txword_enq_v),
        .word_rdy (txword_enq__RDY),
        .err      (err_tx)
    );

    rx_state_t            rx_state;
    rx_state_t            rx_state_next;
    hdr_t                 rx_hdr;
    hdr_t                 word_hdr;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic [LEN_W-1:0]     rx_idx;
    logic                 rx_err;
    logic                 rx_xfer;
    logic                 unused_rx_upper;

    // Upper half of the header word carries nothing.
    assign unused_rx_upper = &{1'b0, rxword_enq_v[WORD_W-1:HDR_W]};
    assign word_hdr        = hdr_t'(rxword_enq_v[HDR_W-1:0]);
    assign rx_xfer         = rxword_enq__ENA & (rx_state != R_DELIVER);
    assign request_enq_v   = {rx_hdr, rx_payload};
    assign err_rx          = rx_err;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rx_state <= R_HDR;
        else       rx_state <= rx_state_next;
    end

    always_comb begin
        rx_state_next = rx_state;
        case (rx_state)
            R_HDR:     if (rx_xfer) rx_state_next = (word_hdr.len == '0) ? R_DELIVER : R_BODY;
            R_BODY:    if (rx_xfer && rx_idx == rx_hdr.len - LEN_W'(1)) rx_state_next = R_DELIVER;
            R_DELIVER: if (request_enq__ENA) rx_state_next = R_HDR;
            default:   rx_state_next = R_HDR;
        endcase
    end

    always_comb begin
        rxword_enq__RDY  = (rx_state != R_DELIVER);
        request_enq__ENA = (rx_state == R_DELIVER) & request_enq__RDY;
    end

    // Words past the buffer are counted but dropped, so overlong messages stay framed.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rx_hdr     <= '0;
            rx_payload <= '0;
            rx_idx     <= '0;
            rx_err     <= 1'b0;
        end else if (rx_xfer && rx_state == R_HDR) begin
            rx_hdr     <= word_hdr;
            rx_payload <= '0;
            rx_idx     <= '0;
            if (len_over(word_hdr.len)) rx_err <= 1'b1;
        end else if (rx_xfer && rx_state == R_BODY) begin
            if (rx_idx < LEN_W'(PAYLOAD_WORDS))
                rx_payload[32'(rx_idx[1:0]) * WORD_W +: WORD_W] <= rxword_enq_v;
            rx_idx <= rx_idx + LEN_W'(1);
        end
    end

endmodule

// File: tb/tb_l_pipe_word_bridge.sv
// Directed bench for l_pipe_word_bridge: TX/RX framing, backpressure, overlength and mid-message reset.
module tb_l_pipe_word_bridge;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         indication_enq__ENA;
    logic [143:0] indication_enq_v;
    logic         indication_enq__RDY;
    logic         txword_enq__ENA;
    logic [31:0]  txword_enq_v;
    logic         txword_enq__RDY;
    logic         rxword_enq__ENA;
    logic [31:0]  rxword_enq_v;
    logic         rxword_enq__RDY;
    logic         request_enq__ENA;
    logic [143:0] request_enq_v;
    logic         request_enq__RDY;
    logic         err_tx;
    logic         err_rx;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    always #5 CLK = ~CLK;

    l_pipe_word_bridge dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .indication_enq__ENA (indication_enq__ENA),
        .indication_enq_v    (indication_enq_v),
        .indication_enq__RDY (indication_enq__RDY),
        .txword_enq__ENA     (txword_enq__ENA),
        .txword_enq_v        (txword_enq_v),
        .txword_enq__RDY     (txword_enq__RDY),
        .rxword_enq__ENA     (rxword_enq__ENA),
        .rxword_enq_v        (rxword_enq_v),
        .rxword_enq__RDY     (rxword_enq__RDY),
        .request_enq__ENA    (request_enq__ENA),
        .request_enq_v       (request_enq_v),
        .request_enq__RDY    (request_enq__RDY),
        .err_tx              (err_tx),
        .err_rx              (err_rx)
    );

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        indication_enq__ENA = 1'b0; indication_enq_v = '0; txword_enq__RDY = 1'b0;
        rxword_enq__ENA = 1'b0; rxword_enq_v = '0; request_enq__RDY = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_ind_rdy", 144'(indication_enq__RDY), 144'(1));
        chk("rst_rx_rdy",  144'(rxword_enq__RDY), 144'(1));
        chk("rst_tx_ena",  144'(txword_enq__ENA), 144'(0));
        chk("rst_req_ena", 144'(request_enq__ENA), 144'(0));
        chk("rst_tx_v",    144'(txword_enq_v), 144'(0));
        chk("rst_req_v",   request_enq_v, 144'(0));
        chk("rst_err_tx",  144'(err_tx), 144'(0));
        chk("rst_err_rx",  144'(err_rx), 144'(0));
        @(negedge CLK);
        nRST = 1'b1;

        // TX basic: L=2 -> header word plus two payload words
        @(negedge CLK);
        txword_enq__RDY = 1'b1;
        indication_enq__ENA = 1'b1;
        indication_enq_v = {16'h0302, 32'h44, 32'h33, 32'h22, 32'h11};
        #1 chk("txb_ind_rdy_idle", 144'(indication_enq__RDY), 144'(1));
        @(negedge CLK);
        indication_enq__ENA = 1'b0; indication_enq_v = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("txb_ena", 144'(txword_enq__ENA), 144'(1));
            chk("txb_word", 144'(txword_enq_v), (i == 0) ? 144'h0302 : 144'(32'(i) * 32'h11));
            chk("txb_ind_rdy_busy", 144'(indication_enq__RDY), 144'(0));
            @(negedge CLK);
        end
        #1;
        chk("txb_done_ena", 144'(txword_enq__ENA), 144'(0));
        chk("txb_done_rdy", 144'(indication_enq__RDY), 144'(1));
        chk("txb_err_tx",   144'(err_tx), 144'(0));

        // TX L=0 under backpressure: one header word held until accepted
        @(negedge CLK);
        txword_enq__RDY = 1'b0;
        indication_enq__ENA = 1'b1;
        indication_enq_v = {16'h0500, 128'hDEAD_BEEF};
        @(negedge CLK);
        indication_enq__ENA = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("txz_stall_ena", 144'(txword_enq__ENA), 144'(0));
            chk("txz_stall_word", 144'(txword_enq_v), 144'h0500);
            chk("txz_stall_rdy", 144'(indication_enq__RDY), 144'(0));
            @(negedge CLK);
        end
        txword_enq__RDY = 1'b1;
        #1;
        chk("txz_ena", 144'(txword_enq__ENA), 144'(1));
        chk("txz_word", 144'(txword_enq_v), 144'h0500);
        @(negedge CLK);
        #1;
        chk("txz_done_ena", 144'(txword_enq__ENA), 144'(0));
        chk("txz_done_rdy", 144'(indication_enq__RDY), 144'(1));
        chk("txz_err_tx",   144'(err_tx), 144'(0));

        // TX L=6: clamped to four payload words, err_tx set; a mid-send ENA is ignored
        @(negedge CLK);
        indication_enq__ENA = 1'b1;
        indication_enq_v = {16'h0106, 32'hA4, 32'hA3, 32'hA2, 32'hA1};
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            indication_enq__ENA = (i == 2);
            indication_enq_v = (i == 2) ? '1 : '0;
            #1;
            chk("txo_ena", 144'(txword_enq__ENA), 144'(1));
            chk("txo_word", 144'(txword_enq_v), (i == 0) ? 144'h0106 : 144'(32'hA0 + 32'(i)));
            chk("txo_err_tx", 144'(err_tx), 144'(1));
            @(negedge CLK);
        end
        indication_enq__ENA = 1'b0; indication_enq_v = '0;
        #1;
        chk("txo_done_ena", 144'(txword_enq__ENA), 144'(0));
        chk("txo_done_rdy", 144'(indication_enq__RDY), 144'(1));

        // RX basic: L=2, consumer stalls three cycles
        @(negedge CLK);
        request_enq__RDY = 1'b0;
        rxword_enq__ENA = 1'b1;
        rxword_enq_v = 32'hFFFF_0702;
        #1 chk("rxb_rdy_hdr", 144'(rxword_enq__RDY), 144'(1));
        @(negedge CLK);
        rxword_enq_v = 32'h0000_AAAA;
        #1 chk("rxb_rdy_body", 144'(rxword_enq__RDY), 144'(1));
        @(negedge CLK);
        rxword_enq_v = 32'h0000_BBBB;
        @(negedge CLK);
        rxword_enq__ENA = 1'b0; rxword_enq_v = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rxb_hold_rdy", 144'(rxword_enq__RDY), 144'(0));
            chk("rxb_hold_ena", 144'(request_enq__ENA), 144'(0));
            chk("rxb_msg", request_enq_v, {16'h0702, 64'h0, 32'h0000_BBBB, 32'h0000_AAAA});
            @(negedge CLK);
        end
        request_enq__RDY = 1'b1;
        #1 chk("rxb_req_ena", 144'(request_enq__ENA), 144'(1));
        @(negedge CLK);
        #1;
        chk("rxb_after_ena", 144'(request_enq__ENA), 144'(0));
        chk("rxb_after_rdy", 144'(rxword_enq__RDY), 144'(1));
        chk("rxb_err_rx",    144'(err_rx), 144'(0));

        // RX overlength: L=6, words 5 and 6 absorbed
        @(negedge CLK);
        rxword_enq__ENA = 1'b1;
        rxword_enq_v = 32'h0000_0006;
        @(negedge CLK);
        #1 chk("rxo_err_set", 144'(err_rx), 144'(1));
        for (int i = 1; i <= 6; i++) begin
            rxword_enq_v = 32'(i);
            #1 chk("rxo_rdy", 144'(rxword_enq__RDY), 144'(1));
            @(negedge CLK);
        end
        rxword_enq__ENA = 1'b0; rxword_enq_v = '0;
        #1;
        chk("rxo_req_ena", 144'(request_enq__ENA), 144'(1));
        chk("rxo_msg", request_enq_v, {16'h0006, 32'd4, 32'd3, 32'd2, 32'd1});
        @(negedge CLK);
        #1;
        chk("rxo_after_ena", 144'(request_enq__ENA), 144'(0));
        chk("rxo_err_sticky", 144'(err_rx), 144'(1));

        // Concurrent TX/RX, reset pulsed mid RX body
        @(negedge CLK);
        indication_enq__ENA = 1'b1;
        indication_enq_v = {16'h0203, 32'hB4, 32'hB3, 32'hB2, 32'hB1};
        rxword_enq__ENA = 1'b1;
        rxword_enq_v = 32'h0000_0003;
        @(negedge CLK);
        indication_enq__ENA = 1'b0; indication_enq_v = '0;
        rxword_enq_v = 32'h11;
        #1;
        chk("cr_tx_ena", 144'(txword_enq__ENA), 144'(1));
        chk("cr_tx_hdr", 144'(txword_enq_v), 144'h0203);
        @(negedge CLK);
        rxword_enq_v = 32'h22;
        #1;
        chk("cr_tx_w1", 144'(txword_enq_v), 144'hB1);
        chk("cr_rx_rdy", 144'(rxword_enq__RDY), 144'(1));
        @(negedge CLK);
        rxword_enq__ENA = 1'b0; rxword_enq_v = '0;
        nRST = 1'b0;
        #1;
        chk("cr_rst_rx_rdy",  144'(rxword_enq__RDY), 144'(1));
        chk("cr_rst_req_ena", 144'(request_enq__ENA), 144'(0));
        chk("cr_rst_tx_ena",  144'(txword_enq__ENA), 144'(0));
        chk("cr_rst_tx_v",    144'(txword_enq_v), 144'(0));
        chk("cr_rst_ind_rdy", 144'(indication_enq__RDY), 144'(1));
        chk("cr_rst_req_v",   request_enq_v, 144'(0));
        chk("cr_rst_err_tx",  144'(err_tx), 144'(0));
        chk("cr_rst_err_rx",  144'(err_rx), 144'(0));
        @(negedge CLK);
        nRST = 1'b1;
        #1 chk("cr_post_req_ena", 144'(request_enq__ENA), 144'(0));

        // Next full message on each path after reset
        @(negedge CLK);
        indication_enq__ENA = 1'b1;
        indication_enq_v = {16'h0901, 96'h0, 32'hC1};
        rxword_enq__ENA = 1'b1;
        rxword_enq_v = 32'h0000_0001;
        request_enq__RDY = 1'b1;
        @(negedge CLK);
        indication_enq__ENA = 1'b0; indication_enq_v = '0;
        rxword_enq_v = 32'hD1;
        #1;
        chk("fn_tx_ena", 144'(txword_enq__ENA), 144'(1));
        chk("fn_tx_hdr", 144'(txword_enq_v), 144'h0901);
        @(negedge CLK);
        rxword_enq__ENA = 1'b0; rxword_enq_v = '0;
        #1;
        chk("fn_tx_w1",    144'(txword_enq_v), 144'hC1);
        chk("fn_tx_ena1",  144'(txword_enq__ENA), 144'(1));
        chk("fn_req_ena",  144'(request_enq__ENA), 144'(1));
        chk("fn_req_msg",  request_enq_v, {16'h0001, 96'h0, 32'hD1});
        @(negedge CLK);
        #1;
        chk("fn_idle_tx_ena",  144'(txword_enq__ENA), 144'(0));
        chk("fn_idle_req_ena", 144'(request_enq__ENA), 144'(0));
        chk("fn_idle_ind_rdy", 144'(indication_enq__RDY), 144'(1));
        chk("fn_idle_rx_rdy",  144'(rxword_enq__RDY), 144'(1));
        chk("fn_err_tx",       144'(err_tx), 144'(0));
        chk("fn_err_rx",       144'(err_rx), 144'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
